// File: rtl/gpio_bank.sv
// gpio_bank: WIDTH-bit GPIO with direction, set/clear/toggle,
// synchronised input readback and edge-detect interrupts on the PicoRV32 bus.
module gpio_bank #(
    parameter logic [31:0]      BASE    = 32'h0000_0000,
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_OUT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    output logic             mem_port_ready,
    output logic [31:0]      mem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   sel, accept, wr;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ien_q, ien_d;
    logic [WIDTH-1:0] stat_q, stat_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] s1_q, s2_q, prev_q;
    logic [WIDTH-1:0] ev, stat_clr;
    logic [WIDTH-1:0] bm, d, rd;
    logic [31:0]      bm32, d32, rdata_d, rdata_q;

    logic [3:0] idx;
    logic hit_out, hit_dir, hit_in, hit_set, hit_clr;
    logic hit_tgl, hit_ien, hit_stat, hit_edge;

    assign sel = mem_valid && (mem_addr[31:6] == BASE[31:6]);
    assign idx = mem_addr[5:2];

    assign hit_out  = (idx == 4'd0);
    assign hit_dir  = (idx == 4'd1);
    assign hit_in   = (idx == 4'd2);
    assign hit_set  = (idx == 4'd3);
    assign hit_clr  = (idx == 4'd4);
    assign hit_tgl  = (idx == 4'd5);
    assign hit_ien  = (idx == 4'd6);
    assign hit_stat = (idx == 4'd7);
    assign hit_edge = (idx == 4'd8);

    // busy holds off a second ack until the master drops mem_valid
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        accept  = 1'b0;
        if (!mem_valid)
            busy_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel && !mem_ready && !busy_q && !reset) begin
                    accept  = 1'b1;
                    state_d = ACK;
                    busy_d  = 1'b1;
                end
            end
            ACK: state_d = IDLE;
        endcase
    end

    assign wr = accept && (mem_wstrb != 4'b0000);

    assign bm32 = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                   {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
    assign d32  = mem_wdata & bm32;
    assign bm   = bm32[WIDTH-1:0];
    assign d    = d32[WIDTH-1:0];

    always_comb begin
        rd = '0;
        unique case (1'b1)
            hit_out:  rd = out_q;
            hit_dir:  rd = dir_q;
            hit_in:   rd = s2_q;
            hit_ien:  rd = ien_q;
            hit_stat: rd = stat_q;
            hit_edge: rd = edge_q;
            default:  rd = '0;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        rdata_d[WIDTH-1:0] = rd;
    end

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        ien_d  = ien_q;
        edge_d = edge_q;
        if (wr) begin
            unique case (1'b1)
                hit_out:  out_d  = (out_q & ~bm) | d;
                hit_set:  out_d  = out_q | d;
                hit_clr:  out_d  = out_q & ~d;
                hit_tgl:  out_d  = out_q ^ d;
                hit_dir:  dir_d  = (dir_q & ~bm) | d;
                hit_ien:  ien_d  = (ien_q & ~bm) | d;
                hit_edge: edge_d = (edge_q & ~bm) | d;
                default:  ;
            endcase
        end
    end

    // a fresh event outranks a same-cycle write-1-to-clear
    assign stat_clr = (wr && hit_stat) ? d : '0;
    assign ev       = (edge_q & ~s2_q & prev_q) | (~edge_q & s2_q & ~prev_q);
    assign stat_d   = (stat_q & ~stat_clr) | ev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            out_q   <= RST_OUT;
            dir_q   <= '0;
            ien_q   <= '0;
            stat_q  <= '0;
            edge_q  <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            rdata_q <= accept ? rdata_d : '0;
            out_q   <= out_d;
            dir_q   <= dir_d;
            ien_q   <= ien_d;
            stat_q  <= stat_d;
            edge_q  <= edge_d;
            s1_q    <= gpio_in;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
        end
    end

    assign mem_port_ready = (state_q == ACK);
    assign mem_rdata      = rdata_q;
    assign gpio_out       = out_q;
    assign gpio_oe        = dir_q;
    assign irq            = |(stat_q & ien_q);

    logic unused_bits;
    assign unused_bits = ^{mem_addr[1:0], d32, bm32};

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed checks of gpio_bank register map,
// bus handshake, input sync and edge interrupts.
module tb_gpio_bank;

    localparam logic [31:0] BASE = 32'h8000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_port_ready;
    logic [31:0] mem_rdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    int checks = 0;
    int errors = 0;

    gpio_bank #(
        .BASE    (BASE),
        .WIDTH   (8),
        .RST_OUT (8'hA5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_valid      (mem_valid),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_ready      (mem_ready),
        .mem_port_ready (mem_port_ready),
        .mem_rdata      (mem_rdata),
        .gpio_in        (gpio_in),
        .gpio_out       (gpio_out),
        .gpio_oe        (gpio_oe),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata,
                        output bit acked);
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        acked = 1'b0;
        rdata = '0;
        for (int i = 0; i < 3 && !acked; i++) begin
            @(posedge clk);
            #1;
            if (mem_port_ready) begin
                acked = 1'b1;
                rdata = mem_rdata;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
    endtask

    task automatic wr(input string tag, input logic [7:0] off,
                      input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [31:0] r;
        bit a;
        xfer(BASE + 32'(off), wdata, wstrb, r, a);
        chk(tag, 32'(a), 32'd1);
    endtask

    task automatic rd(input string tag, input logic [7:0] off,
                      input logic [31:0] exp);
        logic [31:0] r;
        bit a;
        xfer(BASE + 32'(off), 32'h0, 4'b0000, r, a);
        chk({tag, "_ack"}, 32'(a), 32'd1);
        chk(tag, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        bit a;
        int cnt;

        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        mem_ready = 1'b0;
        gpio_in   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", 32'(gpio_out), 32'hA5);
        chk("rst_oe", 32'(gpio_oe), 32'h00);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ready", 32'(mem_port_ready), 32'd0);
        chk("rst_rdata", mem_rdata, 32'h0);
        reset = 1'b0;

        rd("rd_out_rst", 8'h00, 32'h0000_00A5);
        @(posedge clk);
        #1;
        chk("ack_width", 32'(mem_port_ready), 32'd0);
        chk("rdata_idle", mem_rdata, 32'h0);

        xfer(BASE, 32'h1234_560F, 4'b1111, r, a);
        chk("wr_out_ack", 32'(a), 32'd1);
        chk("wr_out_oldval", r, 32'h0000_00A5);
        chk("out_0f", 32'(gpio_out), 32'h0F);
        rd("rd_out_0f", 8'h00, 32'h0000_000F);
        wr("set_ack", 8'h0C, 32'h30, 4'b1111);
        chk("out_set", 32'(gpio_out), 32'h3F);
        wr("clr_ack", 8'h10, 32'h03, 4'b1111);
        chk("out_clr", 32'(gpio_out), 32'h3C);
        wr("tgl_ack", 8'h14, 32'h81, 4'b1111);
        chk("out_tgl", 32'(gpio_out), 32'hBD);
        wr("set_strb_ack", 8'h0C, 32'h0000_FF40, 4'b0010);
        chk("out_set_strb", 32'(gpio_out), 32'hBD);
        rd("rd_set_wo", 8'h0C, 32'h0);

        wr("dir_strb_ack", 8'h04, 32'hFF, 4'b0010);
        chk("oe_strb", 32'(gpio_oe), 32'h00);
        rd("rd_dir_0", 8'h04, 32'h0);
        wr("dir_ack", 8'h04, 32'hFF, 4'b0001);
        chk("oe_ff", 32'(gpio_oe), 32'hFF);

        wr("ien4_ack", 8'h18, 32'h04, 4'b1111);
        @(negedge clk);
        gpio_in = 8'h04;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("irq_2edges", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        chk("irq_3edges", 32'(irq), 32'd1);
        rd("rd_in", 8'h08, 32'h04);
        rd("rd_stat4", 8'h1C, 32'h04);
        wr("w1c4_ack", 8'h1C, 32'h04, 4'b1111);
        chk("irq_w1c", 32'(irq), 32'd0);
        rd("rd_stat_clr", 8'h1C, 32'h0);

        wr("edge_ack", 8'h20, 32'h01, 4'b1111);
        wr("ien1_ack", 8'h18, 32'h01, 4'b1111);
        rd("rd_edge", 8'h20, 32'h01);
        @(negedge clk);
        gpio_in = 8'h05;
        repeat (4) @(posedge clk);
        rd("rd_stat_rise", 8'h1C, 32'h0);
        @(negedge clk);
        gpio_in = 8'h04;
        repeat (4) @(posedge clk);
        rd("rd_stat_fall", 8'h1C, 32'h01);
        chk("irq_fall", 32'(irq), 32'd1);
        wr("w1c1_ack", 8'h1C, 32'h01, 4'b1111);
        chk("irq_fall_clr", 32'(irq), 32'd0);
        @(negedge clk);
        gpio_in = 8'h05;
        repeat (4) @(posedge clk);

        // second fall lands on the same edge as a W1C of that bit
        @(negedge clk);
        gpio_in = 8'h04;
        @(negedge clk);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h1C;
        mem_wdata = 32'h01;
        mem_wstrb = 4'b1111;
        @(posedge clk);
        #1;
        chk("race_ack", 32'(mem_port_ready), 32'd1);
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        chk("race_irq", 32'(irq), 32'd1);
        rd("rd_stat_race", 8'h1C, 32'h01);

        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h14;
        mem_wdata = 32'h01;
        mem_wstrb = 4'b1111;
        cnt = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (mem_port_ready) cnt++;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        @(posedge clk);
        #1;
        if (mem_port_ready) cnt++;
        chk("held_pulses", 32'(cnt), 32'd1);
        chk("held_tgl_once", 32'(gpio_out), 32'hBC);

        @(negedge clk);
        mem_ready = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = BASE;
        mem_wdata = 32'h55;
        mem_wstrb = 4'b1111;
        cnt = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (mem_port_ready) cnt++;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        mem_ready = 1'b0;
        chk("busy_bus_pulses", 32'(cnt), 32'd0);
        chk("busy_bus_out", 32'(gpio_out), 32'hBC);

        xfer(BASE + 32'h40, 32'h0, 4'b0000, r, a);
        chk("outside_ack", 32'(a), 32'd0);
        wr("hole_wr_ack", 8'h28, 32'hFFFF_FFFF, 4'b1111);
        rd("rd_hole", 8'h28, 32'h0);
        chk("hole_out", 32'(gpio_out), 32'hBC);

        @(negedge clk);
        gpio_in = 8'h00;
        repeat (4) @(posedge clk);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE;
        mem_wdata = 32'h12;
        mem_wstrb = 4'b1111;
        @(posedge clk);
        #1;
        chk("rst_ack_cycle", 32'(mem_port_ready), 32'd1);
        chk("rst_wr_out", 32'(gpio_out), 32'h12);
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        @(posedge clk);
        #1;
        chk("rst2_ready", 32'(mem_port_ready), 32'd0);
        chk("rst2_out", 32'(gpio_out), 32'hA5);
        chk("rst2_oe", 32'(gpio_oe), 32'h00);
        chk("rst2_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd("rst2_dir", 8'h04, 32'h0);
        rd("rst2_ien", 8'h18, 32'h0);
        rd("rst2_stat", 8'h1C, 32'h0);
        rd("rst2_edge", 8'h20, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
